// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline types for register addresses and data words.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/riscv_scoreboard.sv
// riscv_scoreboard: per-register in-flight write counters, busy/issue gating and wb_unexpected.
// REGFILE_BYPASS_EN treats a same-cycle writeback as already committed for busy.
module riscv_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = 32,
    parameter int PEND_W = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t rs1_a,
    input  reg_addr_t rs2_a,
    input  logic      issue_e,
    input  logic      issue_use_rs1,
    input  logic      issue_use_rs2,
    input  reg_addr_t issue_rd,
    input  logic      wb_e,
    input  reg_addr_t wb_a,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      issue_ready,
    output logic      wb_unexpected
);
    logic [PEND_W-1:0] pend [NREG];
    logic [NREG-1:0] inc, dec;
    logic accept, wb_hit, unexpected;

    assign wb_hit = wb_e && wb_a != '0;
`ifdef REGFILE_BYPASS_EN
    assign rs1_busy = (wb_hit && wb_a == rs1_a) ? pend[rs1_a] > PEND_W'(1) : pend[rs1_a] != '0;
    assign rs2_busy = (wb_hit && wb_a == rs2_a) ? pend[rs2_a] > PEND_W'(1) : pend[rs2_a] != '0;
`else
    assign rs1_busy = pend[rs1_a] != '0;
    assign rs2_busy = pend[rs2_a] != '0;
`endif
    assign issue_ready = !((issue_use_rs1 && rs1_busy) || (issue_use_rs2 && rs2_busy) ||
                           (issue_rd != '0 && pend[issue_rd] == '1));
    assign accept = issue_e && issue_ready;
    // a same-cycle issue to the same rd cancels the decrement, so it is not unexpected
    assign unexpected = wb_hit && pend[wb_a] == '0 && !(accept && issue_rd == wb_a);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc[r] = accept && issue_rd == reg_addr_t'(r);
            dec[r] = wb_e && wb_a == reg_addr_t'(r);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
            wb_unexpected <= 1'b0;
        end else begin
            pend[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (inc[r] && !dec[r]) pend[r] <= pend[r] + PEND_W'(1);
                else if (dec[r] && !inc[r] && pend[r] != '0) pend[r] <= pend[r] - PEND_W'(1);
            end
            wb_unexpected <= wb_unexpected | unexpected;
        end
    end
endmodule

// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: integer register file with pending-write scoreboard and retire counter.
// REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module riscv_regfile_sb
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  reg_addr_t       rs1_a,
    input  reg_addr_t       rs2_a,
    output logic [XLEN-1:0] rs1_d,
    output logic [XLEN-1:0] rs2_d,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_e,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  reg_addr_t       issue_rd,
    output logic            issue_ready,
    input  logic            wb_e,
    input  reg_addr_t       wb_a,
    input  logic [XLEN-1:0] wb_d,
    output logic [63:0]     instret,
    output logic            wb_unexpected
);
    logic [XLEN-1:0] regs [NREG];

    riscv_scoreboard #(.NREG(NREG), .PEND_W(PEND_W)) u_sb (
        .clk(clk),
        .reset(reset),
        .rs1_a(rs1_a),
        .rs2_a(rs2_a),
        .issue_e(issue_e),
        .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd),
        .wb_e(wb_e),
        .wb_a(wb_a),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .issue_ready(issue_ready),
        .wb_unexpected(wb_unexpected)
    );

`ifdef REGFILE_BYPASS_EN
    assign rs1_d = (rs1_a == '0) ? '0 : (wb_e && wb_a == rs1_a) ? wb_d : regs[rs1_a];
    assign rs2_d = (rs2_a == '0) ? '0 : (wb_e && wb_a == rs2_a) ? wb_d : regs[rs2_a];
`else
    assign rs1_d = (rs1_a == '0) ? '0 : regs[rs1_a];
    assign rs2_d = (rs2_a == '0) ? '0 : regs[rs2_a];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            instret <= '0;
        end else begin
            if (wb_e && wb_a != '0) regs[wb_a] <= wb_d;
            if (wb_e) instret <= instret + 64'd1;
        end
    end
endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb: directed stimulus with a queue-based scoreboard checked by a negedge monitor.
module tb_riscv_regfile_sb;
    import riscv_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef enum logic [2:0] {F_RS1D, F_RS2D, F_RS1B, F_RS2B, F_RDY, F_INSTRET, F_UNEXP} fld_t;
    typedef struct {
        fld_t        f;
        logic [63:0] v;
        string       n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    reg_addr_t rs1_a, rs2_a, issue_rd, wb_a;
    logic [31:0] rs1_d, rs2_d, wb_d;
    logic rs1_busy, rs2_busy, issue_e, issue_use_rs1, issue_use_rs2, issue_ready, wb_e, wb_unexpected;
    logic [63:0] instret;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_regfile_sb dut (
        .clk(clk),
        .reset(reset),
        .rs1_a(rs1_a),
        .rs2_a(rs2_a),
        .rs1_d(rs1_d),
        .rs2_d(rs2_d),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .issue_e(issue_e),
        .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_e(wb_e),
        .wb_a(wb_a),
        .wb_d(wb_d),
        .instret(instret),
        .wb_unexpected(wb_unexpected)
    );

    function automatic logic [63:0] sel(fld_t f);
        case (f)
            F_RS1D:    return {32'b0, rs1_d};
            F_RS2D:    return {32'b0, rs2_d};
            F_RS1B:    return {63'b0, rs1_busy};
            F_RS2B:    return {63'b0, rs2_busy};
            F_RDY:     return {63'b0, issue_ready};
            F_INSTRET: return instret;
            default:   return {63'b0, wb_unexpected};
        endcase
    endfunction

    // monitor: outputs are valid every cycle, so drain all expectations at each negedge
    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            logic [63:0] act;
            e = q.pop_front();
            act = sel(e.f);
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s actual %0h expected %0h", e.n, act, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(fld_t f, logic [63:0] v, string n);
        q.push_back('{f: f, v: v, n: n});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rs1_a = '0; rs2_a = '0; issue_rd = '0; wb_a = '0; wb_d = '0;
        issue_e = 1'b0; issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; wb_e = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rs1_a = reg_addr_t'(r);
            rs2_a = reg_addr_t'(31 - r);
            exp(F_RS1D, 0, "reset_rs1_d");
            exp(F_RS2D, 0, "reset_rs2_d");
            exp(F_RS1B, 0, "reset_rs1_busy");
            exp(F_RS2B, 0, "reset_rs2_busy");
            if (r == 0) begin
                exp(F_RDY, 1, "reset_ready");
                exp(F_INSTRET, 0, "reset_instret");
                exp(F_UNEXP, 0, "reset_unexp");
            end
            tick();
        end
        // basic write/read, x1 issued first so the writeback is expected
        issue_e = 1'b1; issue_rd = 5'd1;
        exp(F_RDY, 1, "issue_x1_ready");
        tick();
        issue_e = 1'b0; wb_e = 1'b1; wb_a = 5'd1; wb_d = 32'hDEADBEEF; rs1_a = 5'd1;
        exp(F_RS1D, BYP ? 64'hDEADBEEF : 64'h0, "wb_x1_same_cycle_data");
        exp(F_RS1B, BYP ? 0 : 1, "wb_x1_same_cycle_busy");
        tick();
        wb_e = 1'b0;
        exp(F_RS1D, 64'hDEADBEEF, "x1_read");
        exp(F_RS1B, 0, "x1_busy_clear");
        exp(F_INSTRET, 1, "instret_1");
        exp(F_UNEXP, 0, "unexp_clear");
        tick();
        wb_e = 1'b1; wb_a = 5'd0; wb_d = 32'h12345678; rs1_a = 5'd0;
        exp(F_RS1D, 0, "x0_write_same_cycle");
        tick();
        wb_e = 1'b0;
        exp(F_RS1D, 0, "x0_reads_zero");
        exp(F_INSTRET, 2, "instret_x0");
        tick();
        // stall then release on x3
        issue_e = 1'b1; issue_rd = 5'd3;
        exp(F_RDY, 1, "issue_x3_ready");
        tick();
        issue_use_rs1 = 1'b1; rs1_a = 5'd3; issue_rd = 5'd4;
        exp(F_RDY, 0, "raw_stall");
        exp(F_RS1B, 1, "x3_busy");
        tick();
        wb_e = 1'b1; wb_a = 5'd3; wb_d = 32'hFEDCBA98;
        exp(F_RDY, BYP ? 1 : 0, "release_same_cycle_ready");
        exp(F_RS1D, BYP ? 64'hFEDCBA98 : 64'h0, "release_same_cycle_data");
        tick();
        wb_e = 1'b0; issue_e = 1'b0; rs2_a = 5'd4;
        exp(F_RDY, 1, "release_next_ready");
        exp(F_RS1D, 64'hFEDCBA98, "release_next_data");
        exp(F_RS2B, BYP ? 1 : 0, "stalled_issue_no_state");
        tick();
        // counter saturation on x5
        issue_use_rs1 = 1'b0; issue_e = 1'b1; issue_rd = 5'd5; rs2_a = 5'd5;
        for (int i = 0; i < 3; i++) begin
            exp(F_RDY, 1, "sat_issue_accept");
            tick();
        end
        exp(F_RDY, 0, "sat_full");
        exp(F_RS2B, 1, "sat_busy");
        tick();
        issue_e = 1'b0; wb_e = 1'b1; wb_a = 5'd5; wb_d = 32'h55;
        exp(F_RDY, 0, "sat_full_during_wb");
        tick();
        wb_e = 1'b0; issue_e = 1'b1;
        exp(F_RDY, 1, "sat_reissue");
        tick();
        // simultaneous issue and writeback on x7
        issue_rd = 5'd7;
        exp(F_RDY, 1, "issue_x7");
        tick();
        wb_e = 1'b1; wb_a = 5'd7; wb_d = 32'h77; rs1_a = 5'd7;
        exp(F_RDY, 1, "simul_ready");
        tick();
        issue_e = 1'b0; wb_e = 1'b0;
        exp(F_RS1B, 1, "simul_still_busy");
        exp(F_RS1D, 64'h77, "simul_data");
        exp(F_UNEXP, 0, "simul_not_unexp");
        exp(F_INSTRET, 5, "instret_5");
        tick();
        // unexpected writeback to x9
        wb_e = 1'b1; wb_a = 5'd9; wb_d = 32'h99;
        tick();
        wb_e = 1'b0; rs1_a = 5'd9;
        exp(F_UNEXP, 1, "unexp_set");
        exp(F_RS1D, 64'h99, "unexp_data_written");
        exp(F_INSTRET, 6, "instret_6");
        tick();
        // reset mid-flight with pend[2]=2
        issue_e = 1'b1; issue_rd = 5'd2;
        tick();
        tick();
        issue_e = 1'b0; rs1_a = 5'd2;
        exp(F_RS1B, 1, "x2_busy_pre_reset");
        tick();
        reset = 1'b1; issue_e = 1'b1; wb_e = 1'b1; wb_a = 5'd2; wb_d = 32'h2222;
        tick();
        reset = 1'b0; issue_e = 1'b0; wb_e = 1'b0; rs1_a = 5'd2; rs2_a = 5'd9;
        exp(F_RS1B, 0, "post_reset_x2_busy");
        exp(F_RS1D, 0, "post_reset_x2_data");
        exp(F_RS2D, 0, "post_reset_x9_data");
        exp(F_UNEXP, 0, "post_reset_unexp");
        exp(F_INSTRET, 0, "post_reset_instret");
        exp(F_RDY, 1, "post_reset_ready");
        tick();
        rs1_a = 5'd5; rs2_a = 5'd7;
        exp(F_RS1B, 0, "post_reset_x5_busy");
        exp(F_RS2B, 0, "post_reset_x7_busy");
        tick();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Integer register file with a pending-write scoreboard for the five-stage RISC-V pipeline. It consumes the writeback port (`wb_e`/`wb_a`/`wb_d`) driven by the pipeline's WB stage and serves the two decode-stage operand reads. It also tells decode when an instruction must stall because a source or destination register still has an older write in flight. A 64-bit retire counter tracks completed writebacks.

## Interface
- `XLEN`, 32, register and data width
- `NREG`, 32, architectural registers; x0 is hardwired to zero
- `PEND_W`, 2, width of the per-register in-flight write counter
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `rs1_a`, `rs2_a`  in  5  decode source addresses
- `rs1_d`, `rs2_d`  out  XLEN  source operand data, combinational
- `rs1_busy`, `rs2_busy`  out  1  source has an uncommitted pending write
- `issue_e`  in  1  decode requests to issue an instruction
- `issue_use_rs1`, `issue_use_rs2`  in  1  instruction actually reads rs1 / rs2
- `issue_rd`  in  5  destination of the issuing instruction; 0 means no write
- `issue_ready`  out  1  issue accepted this cycle when `issue_e && issue_ready`
- `wb_e`  in  1  writeback valid
- `wb_a`  in  5  writeback destination
- `wb_d`  in  XLEN  writeback data
- `instret`  out  64  count of cycles with `wb_e` high
- `wb_unexpected`  out  1  sticky flag: writeback to a register whose pending count was 0

## Operation
- **Storage:**
  - Registers x1..x31 are written on the clock edge when `wb_e && wb_a != 0`.
  - x0 always reads 0, and writes to x0 are discarded.
- **Reads:** asynchronous. `rsN_d = (rsN_a == 0) ? 0 : regs[rsN_a]`, with the bypass applied when it is compiled in.
- **Pending counters:** each register r != 0 has a counter `pend[r]` of width PEND_W. Next-cycle value:
  - `+1` if an issue is accepted with `issue_rd == r`.
  - `-1` if `wb_e && wb_a == r`.
  - Unchanged if both happen in the same cycle.
  - A decrement while the counter is 0 leaves it at 0 and sets `wb_unexpected`. The data is still written.
  - `pend[0]` is constant 0.
- **Busy:** `rsN_busy = pend[rsN_a] != 0`, with the bypass exception below.
- **Issue gating:** `issue_ready = !((issue_use_rs1 && rs1_busy) || (issue_use_rs2 && rs2_busy) || (issue_rd != 0 && pend[issue_rd] == 2^PEND_W-1))`.
  - `issue_ready` does not depend on `issue_e`.
  - A stalled issue changes no state.
- **`instret`:** increments by 1 on every cycle with `wb_e` high, including writes to x0. It wraps modulo 2^64.
- **Reset:** all registers, all `pend`, `instret` and `wb_unexpected` clear to 0. At reset release all busy outputs are 0 and `issue_ready` is 1.
  - Reset wins over simultaneous `wb_e` or issue.
  - Asserting reset mid-flight discards all pending state.

## Timing
- Read latency is 0 cycles, combinational from address to data.
- A write is visible on the read ports on the cycle after `wb_e`, or in the same cycle when the bypass is enabled.
- A busy flag clears on the cycle after the matching writeback, or in the same cycle when the bypass is enabled.
- An accepted issue makes `rd` busy from the next cycle.
- Simultaneous issue and writeback to the same `rd`: the counter is unchanged and `rd` stays busy.
- No combinational path exists from `issue_e` to any output.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If `wb_e && wb_a == rsN_a && wb_a != 0`, then `rsN_d = wb_d`.
  - `rsN_busy` is computed as if the writeback had already committed: busy only if `pend[rsN_a] > 1`.
- Undefined:
  - No forwarding.
  - A dependent instruction stalls one extra cycle and reads the value from the array.

## Structure
- **Shared package `riscv_pkg`:** holds `XLEN`, `REG_AW = 5`, the typedef `reg_addr_t` and the typedef `xlen_t`. The package is shared with the pipeline.
- **Sub-module `riscv_scoreboard`:** holds the `pend` counter array, busy/ready logic and `wb_unexpected`.
- **Top level:** instantiates the scoreboard and holds the register array, read muxes, bypass and `instret`.

## Test plan
- **Reset:** hold reset 2 cycles, read x0..x31 → every `rsN_d` = 0, busy = 0, `issue_ready` = 1, `instret` = 0.
- **Basic write/read:** `wb_e`=1, `wb_a`=1, `wb_d`=32'hDEADBEEF for 1 cycle → next cycle `rs1_a`=1 gives DEADBEEF and `instret` = 1. A write of 32'h12345678 to x0 leaves x0 reading 0 and makes `instret` = 2.
- **Stall then release:** issue with `issue_rd`=3, then issue with `issue_use_rs1`=1 and `rs1_a`=3 → `issue_ready`=0. Apply writeback x3=32'hFEDCBA98:
  - Bypass on: `issue_ready`=1 and `rs1_d`=FEDCBA98 in the same cycle.
  - Bypass off: both one cycle later.
- **Counter saturation:** issue `rd`=5 three times with no writeback → the third is accepted and the fourth sees `issue_ready`=0. After one writeback to x5 the next issue is accepted.
- **Simultaneous issue and writeback:** with `pend[7]`=1, issue `rd`=7 and writeback x7 in the same cycle → `pend[7]` stays 1 and `rs1_busy` for x7 = 1.
- **Unexpected writeback and reset:** writeback to x9 with `pend[9]`=0 → `wb_unexpected` = 1 and x9 is written. Then assert reset for 1 cycle while `pend[2]`=2 → all flags, counters and `instret` read 0.
